mem_port_arbiter: RTL

Arbitrates one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage) port. It grants one access at a time and sequences each access through a latency countdown. It returns the read data with a one-cycle ready pulse to the owning requester and produces per-port stall signals for the hazard/PC-write logic. Data accesses have priority, and a streak counter prevents fetch starvation.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch port, data port, memory bus and busy flag of mem_port_arbiter.
// Latency: none, wires only.
// Backpressure: none here; the arbiter holds requesters off through ready and stall.
//
// Ports (signals):
//   if_req/if_addr -> arbiter, if_rdata/if_ready/if_stall <- arbiter   (fetch side)
//   d_req/d_we/d_addr/d_wdata -> arbiter, d_rdata/d_ready/d_stall <-   (data side)
//   mem_req/mem_we/mem_addr/mem_wdata <- arbiter, mem_rdata ->         (memory side)
//   busy <- arbiter
// Modports: slave = the arbiter's view, master = the surrounding pipeline/memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported fixed-latency memory between fetch (IF) and data (D) ports.
// Latency: grant in cycle t, ready pulse with read data in t+MEM_LAT, next grant no earlier than t+MEM_LAT+1.
// Backpressure: requesters hold their request until a one-cycle ready; stall = req & ~ready.
//
// Ports: clk, rst (synchronous, active-low); bus (mem_port_arbiter_if.slave) carrying the
// IF request/response, D request/response, memory request bus and the busy flag.
// D wins simultaneous requests; after MAX_STREAK back-to-back D grants with IF waiting, IF wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D}    owner_t;

  localparam logic [3:0] CNT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STREAK_LIM = 4'(MAX_STREAK);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;

  logic              win_d;
  logic              grant;
  logic              resp;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;

  // D takes the memory whenever it asks, except when IF is waiting and has already
  // watched STREAK_LIM data grants go by.
  assign win_d = bus.d_req & ~(bus.if_req & (streak_q == STREAK_LIM));
  assign grant = rst & (state_q == ST_IDLE) & (bus.if_req | bus.d_req);

  // Response cycle is the last WAIT cycle. Gating with rst drops an access that is
  // being abandoned by reset, so no ready escapes for it.
  assign resp = rst & (state_q == ST_WAIT) & (cnt_q == 4'd0);

  assign grant_addr  = win_d ? bus.d_addr  : bus.if_addr;
  assign grant_wdata = win_d ? bus.d_wdata : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_WAIT;
          owner_d = win_d ? OWN_D : OWN_IF;
          cnt_d   = CNT_INIT;
          // Only a D grant that bypassed a waiting fetch lengthens the streak.
          if (win_d && bus.if_req) begin
            streak_d = streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      cnt_q    <= 4'd0;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
    end
  end

  assign bus.mem_req   = grant;
  assign bus.mem_we    = grant & win_d & bus.d_we;
  assign bus.mem_addr  = grant_addr;
  assign bus.mem_wdata = grant_wdata;

  assign bus.if_ready  = resp & (owner_q == OWN_IF);
  assign bus.d_ready   = resp & (owner_q == OWN_D);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  assign bus.if_stall  = bus.if_req & ~bus.if_ready;
  assign bus.d_stall   = bus.d_req & ~bus.d_ready;
  assign bus.busy      = (state_q == ST_WAIT);

endmodule
